// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: round-robin two-requester access controller for a single-port RAM.
module ram_arbiter_2p #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_gnt_o,
   output logic              a_ack_o,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_req_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_gnt_o,
   output logic              b_ack_o,
   output logic [DATA_W-1:0] b_rdata_o,
   output logic              ram_cs_o,
   output logic              ram_rw_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   input  logic [DATA_W-1:0] ram_dout_i,
   output logic              busy_o
);
   localparam logic [1:0] IDLE = 2'b00, ACCESS = 2'b01, ACK = 2'b10;
   logic [1:0]        state_q, state_d;
   logic              we_q, we_d, win_b_q, win_b_d, prio_b_q, prio_b_d;
   logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d, a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   always_comb begin
      state_d   = IDLE;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      win_b_d   = win_b_q;
      prio_b_d  = prio_b_q;
      a_gnt_d   = a_gnt_q;
      b_gnt_d   = b_gnt_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (state_q == IDLE && (a_req_i || b_req_i)) begin
         win_b_d = b_req_i && (!a_req_i || prio_b_q);
         we_d    = win_b_d ? b_we_i : a_we_i;
         addr_d  = win_b_d ? b_addr_i : a_addr_i;
         wdata_d = win_b_d ? b_wdata_i : a_wdata_i;
         a_gnt_d = !win_b_d;
         b_gnt_d = win_b_d;
         state_d = ACCESS;
      end else if (state_q == ACCESS) begin
         a_rdata_d = (!we_q && !win_b_q) ? ram_dout_i : a_rdata_q;
         b_rdata_d = (!we_q && win_b_q) ? ram_dout_i : b_rdata_q;
         a_ack_d   = !win_b_q;
         b_ack_d   = win_b_q;
         state_d   = ACK;
      end else if (state_q == ACK) begin
         a_gnt_d  = 1'b0;
         b_gnt_d  = 1'b0;
         prio_b_d = !win_b_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         win_b_q   <= 1'b0;
         prio_b_q  <= 1'b0;
         a_gnt_q   <= 1'b0;
         b_gnt_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         win_b_q   <= win_b_d;
         prio_b_q  <= prio_b_d;
         a_gnt_q   <= a_gnt_d;
         b_gnt_q   <= b_gnt_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end
   // RAM pins depend only on state and latched request, never on live requester inputs
   assign ram_cs_o   = state_q == ACCESS;
   assign ram_rw_o   = state_q == ACCESS && we_q;
   assign ram_addr_o = addr_q;
   assign ram_din_o  = wdata_q;
   assign busy_o     = state_q != IDLE;
   assign a_gnt_o    = a_gnt_q;
   assign b_gnt_o    = b_gnt_q;
   assign a_ack_o    = a_ack_q;
   assign b_ack_o    = b_ack_q;
   assign a_rdata_o  = a_rdata_q;
   assign b_rdata_o  = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: randomized and directed bench against a transaction-level arbiter model.
module tb_ram_arbiter_2p;
   logic        clk = 1'b0, rst = 1'b1, clr = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [2:0]  a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic        a_gnt, a_ack, b_gnt, b_ack, ram_cs, ram_rw, busy;
   logic [15:0] a_rdata, b_rdata, ram_din, ram_dout;
   logic [2:0]  ram_addr;
   logic [15:0] mem [8];
   int          errors = 0, checks = 0;
   logic [15:0] sm [8];
   logic [15:0] exp_rd [2];
   bit          prio_b = 1'b0;

   ram_arbiter_2p #(.ADDR_W(3), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_gnt_o(a_gnt), .a_ack_o(a_ack), .a_rdata_o(a_rdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_gnt_o(b_gnt), .b_ack_o(b_ack), .b_rdata_o(b_rdata),
      .ram_cs_o(ram_cs), .ram_rw_o(ram_rw), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
      .ram_dout_i(ram_dout), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // 8x16 RAM: combinational read, write at the rising edge while cs and rw are high
   assign ram_dout = (ram_cs && !ram_rw) ? mem[ram_addr] : 16'h0;
   always @(posedge clk) begin
      if (clr) for (int i = 0; i < 8; i++) mem[i] <= '0;
      else if (ram_cs && ram_rw) mem[ram_addr] <= ram_din;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {a_gnt, b_gnt, a_ack, b_ack, ram_cs, ram_rw, busy}, 0);
      check({tag, "_rd"}, {a_rdata, b_rdata}, 0);
      check({tag, "_ram"}, {ram_addr, ram_din}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      prio_b = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      check_reset_outputs("reset");
   endtask

   // One burst: raise the selected requests together and follow them to completion.
   task automatic run(input bit ra, input bit rb, input bit wa, input bit wb,
                      input logic [2:0] aa, input logic [2:0] ab,
                      input logic [15:0] da, input logic [15:0] db);
      int ord [2];
      int n, p, ph;
      bit we_p;
      logic [2:0] ad_p;
      logic [15:0] d_p;
      a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
      b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
      n = int'(ra) + int'(rb);
      if (ra && rb) begin
         ord[0] = prio_b ? 1 : 0;
         ord[1] = prio_b ? 0 : 1;
      end else begin
         ord[0] = rb ? 1 : 0;
         ord[1] = 0;
      end
      for (int c = 1; c <= 3 * n; c++) begin
         tick();
         p    = ord[(c - 1) / 3];
         ph   = (c - 1) % 3;
         we_p = p ? wb : wa;
         ad_p = p ? ab : aa;
         d_p  = p ? db : da;
         check("one_hot_gnt", {31'b0, a_gnt & b_gnt}, 0);
         check("one_hot_ack", {31'b0, a_ack & b_ack}, 0);
         if (ph == 0) begin
            check("gnt", {a_gnt, b_gnt}, p ? 2 'b01 : 2'b10);
            check("acc_cs_rw_busy", {ram_cs, ram_rw, busy}, {1'b1, we_p, 1'b1});
            check("acc_addr", ram_addr, ad_p);
            if (we_p) begin
               check("acc_din", ram_din, d_p);
               sm[ad_p] = d_p;
            end
            // inputs after the grant edge must not matter
            if (p) begin
               b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = 16'($urandom);
            end else begin
               a_we = 1'($urandom); a_addr = 3'($urandom); a_wdata = 16'($urandom);
            end
         end else if (ph == 1) begin
            check("ack", {a_ack, b_ack}, p ? 2'b01 : 2'b10);
            check("ack_cs_busy", {ram_cs, ram_rw, busy}, 3'b001);
            if (!we_p) exp_rd[p] = sm[ad_p];
            check(p ? "b_rdata" : "a_rdata", p ? b_rdata : a_rdata, exp_rd[p]);
            if (p) b_req = 1'b0;
            else a_req = 1'b0;
         end else begin
            check("idle_ctl", {a_gnt, b_gnt, a_ack, b_ack, ram_cs, busy}, 0);
            prio_b = (p == 0);
         end
      end
      check("hold_a_rdata", a_rdata, exp_rd[0]);
      check("hold_b_rdata", b_rdata, exp_rd[1]);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) sm[i] = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      a_req = 1'b1;
      b_req = 1'b1;
      tick();
      tick();
      clr = 1'b0;
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      run(1, 1, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0);
      run(1, 0, 1, 0, 3'd6, 3'd0, 16'hABCD, 16'h0);
      run(1, 0, 0, 0, 3'd6, 3'd0, 16'h0, 16'h0);
      check("read6", a_rdata, 16'hABCD);
      do_reset();
      run(1, 1, 1, 1, 3'd1, 3'd1, 16'h1111, 16'h2222);
      run(1, 0, 0, 0, 3'd1, 3'd0, 16'h0, 16'h0);
      check("read1", a_rdata, 16'h2222);
      do_reset();
      for (int k = 0; k < 3; k++) run(1, 1, 0, 0, 3'(k), 3'(k + 4), 16'h0, 16'h0);
      run(1, 0, 1, 0, 3'd4, 3'd0, 16'h1234, 16'h0);
      run(1, 0, 0, 0, 3'd4, 3'd0, 16'h0, 16'h0);
      run(0, 1, 0, 1, 3'd0, 3'd3, 16'h0, 16'h0F0F);
      run(0, 1, 0, 0, 3'd0, 3'd3, 16'h0, 16'h0);
      check("iso_b", b_rdata, 16'h0F0F);
      check("iso_a", a_rdata, 16'h1234);
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_wdata = 16'h5555; b_req = 1'b0;
      tick();
      check("mid_cs", {ram_cs, ram_rw, a_gnt}, 3'b111);
      rst = 1'b1;
      a_req = 1'b0;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      sm[2] = 16'h5555;
      prio_b = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      tick();
      check("mid_no_ack", {a_ack, b_ack, busy}, 0);
      run(1, 0, 0, 0, 3'd2, 3'd0, 16'h0, 16'h0);
      check("read2", a_rdata, 16'h5555);
      for (int i = 0; i < 40; i++) begin
         bit ra, rb;
         ra = 1'($urandom);
         rb = 1'($urandom);
         if (!ra && !rb) ra = 1'b1;
         run(ra, rb, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
             16'($urandom), 16'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
